// File: rtl/sd_cmd_frame_tx_pkg.sv
// Shared definitions for the SD command framer.
//   sd_state_e    : framer state encoding
//   SD_HDR_BITS   : start + tx + index + argument bits fed through the CRC
//   SD_CRC_BITS   : CRC7 trailer length
//   SD_FRAME_BITS : complete frame length on the line
//   SD_START_TX   : the two fixed leading bits {start, tx}
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    CRC  = 3'd2,
    END  = 3'd3,
    GAP  = 3'd4
  } sd_state_e;

  localparam int         SD_HDR_BITS   = 40;
  localparam int         SD_CRC_BITS   = 7;
  localparam int         SD_FRAME_BITS = 48;
  localparam logic [1:0] SD_START_TX   = 2'b01;

endpackage

// File: rtl/sd_cmd_frame_tx_if.sv
// Command request bus between a command source and the SD command framer.
//   cmd_valid : request present; index/arg held stable until accepted
//   cmd_ready : framer idle and able to accept
//   cmd_index : 6-bit command index
//   cmd_arg   : 32-bit command argument
//   abort     : cancel the frame currently on the line
// master = command source, slave = framer.
interface sd_cmd_frame_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        abort;

  modport master (output cmd_valid, output cmd_index, output cmd_arg, output abort,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_index, input  cmd_arg, input  abort,
                  output cmd_ready);
endinterface

// File: rtl/sd_cmd_frame_tx_crc7.sv
// Serial CRC7 generator, polynomial x^7 + x^3 + 1.
//   CLK, RSTn : clock, asynchronous active-low reset (loads RST_SEED_VAL)
//   clear     : synchronous reload of RST_SEED_VAL, wins over enable
//   enable    : 1 = absorb 'in' into the remainder, 0 = shift remainder out zero-filled
//   in        : serial data bit, MSB first
//   out       : remainder MSB; during drain this is the next CRC bit
module crc7_h45_serial #(
  parameter logic [6:0] RST_SEED_VAL = 7'h00
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  input  logic enable,
  input  logic in,
  output logic out
);
  logic [6:0] crc;
  logic       fb;

  // With enable low the feedback is forced to zero, so the register simply
  // shifts its remainder out MSB first and fills with zeros.
  assign fb  = enable & (in ^ crc[6]);
  assign out = crc[6];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      crc <= RST_SEED_VAL;
    end else if (clear) begin
      crc <= RST_SEED_VAL;
    end else begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end
endmodule

// File: rtl/sd_cmd_frame_tx.sv
// SD-style serial command framer.
// Accepts {index, arg} over a valid/ready bus and sends one 48-bit frame MSB first:
// start(0), tx(1), index[5:0], arg[31:0], CRC7[6:0], end(1); then holds the line
// idle-high for GAP_BITS clocks before accepting the next command.
//   CLK, RSTn : bit clock, asynchronous active-low reset
//   cmd       : command request bus (slave side), includes abort
//   cmd_out   : registered serial line value, idles at 1
//   cmd_oe    : registered drive enable, high for exactly the 48 frame bits
//   busy      : inverse of cmd_ready
//   done      : one-clock pulse coincident with the end bit on cmd_out
module sd_cmd_frame_tx
  import sd_pkg::*;
#(
  parameter int unsigned GAP_BITS = 8,
  parameter logic [6:0]  CRC_SEED = 7'h00
) (
  input  logic             CLK,
  input  logic             RSTn,
  sd_cmd_frame_tx_if.slave cmd,
  output logic             cmd_out,
  output logic             cmd_oe,
  output logic             busy,
  output logic             done
);
  sd_state_e              state, state_nx;
  logic [SD_HDR_BITS-1:0] shift_reg;
  logic [5:0]             bit_cnt;
  logic [7:0]             gap_cnt;
  logic                   accept, active, abort_hit;
  logic                   crc_clear, crc_en, crc_in, crc_out;
  logic                   out_nx, oe_nx, done_nx;

  assign accept        = (state == IDLE) && cmd.cmd_valid;
  assign active        = (state == HDR) || (state == CRC) || (state == END);
  assign abort_hit     = active && cmd.abort;
  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  // The CRC only runs during HDR (absorb) and CRC (drain); everywhere else it is
  // held at the seed so the next frame starts clean, including right after an abort.
  assign crc_en    = (state == HDR);
  assign crc_in    = shift_reg[SD_HDR_BITS-1];
  assign crc_clear = !((state == HDR) || (state == CRC)) || abort_hit;

  crc7_h45_serial #(.RST_SEED_VAL(CRC_SEED)) u_crc (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .clear  (crc_clear),
    .enable (crc_en),
    .in     (crc_in),
    .out    (crc_out)
  );

  always_comb begin
    state_nx = state;
    out_nx   = 1'b1;
    oe_nx    = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: if (cmd.cmd_valid) state_nx = HDR;
      HDR: begin
        out_nx = shift_reg[SD_HDR_BITS-1];
        oe_nx  = 1'b1;
        if (bit_cnt == 6'(SD_HDR_BITS - 1)) state_nx = CRC;
      end
      CRC: begin
        out_nx = crc_out;
        oe_nx  = 1'b1;
        if (bit_cnt == 6'(SD_CRC_BITS - 1)) state_nx = END;
      end
      END: begin
        oe_nx    = 1'b1;
        done_nx  = 1'b1;
        state_nx = GAP;
      end
      GAP: if (gap_cnt == 8'(GAP_BITS - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort overrides whatever the phase would have done on this edge,
    // including the END -> GAP transition that would otherwise pulse done.
    if (abort_hit) begin
      state_nx = GAP;
      out_nx   = 1'b1;
      oe_nx    = 1'b0;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      cmd_out <= 1'b1;
      cmd_oe  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      // Counters restart on every state entry; they only advance inside a phase.
      bit_cnt <= ((state_nx == state) && ((state == HDR) || (state == CRC))) ?
                 bit_cnt + 6'd1 : 6'd0;
      gap_cnt <= ((state_nx == state) && (state == GAP)) ? gap_cnt + 8'd1 : 8'd0;
      cmd_out <= out_nx;
      cmd_oe  <= oe_nx;
      done    <= done_nx;
    end
  end

  // Header payload: captured only at accept, so later bus changes cannot leak in.
  always_ff @(posedge CLK) begin
    if (accept) begin
      shift_reg <= {SD_START_TX, cmd.cmd_index, cmd.cmd_arg};
    end else if (state == HDR) begin
      shift_reg <= {shift_reg[SD_HDR_BITS-2:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_sd_cmd_frame_tx.sv
`timescale 1ns/1ps
module tb_sd_cmd_frame_tx;
  import sd_pkg::*;

  localparam int GAP = 8;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic cmd_out, cmd_oe, busy, done;

  sd_cmd_frame_tx_if bus();

  sd_cmd_frame_tx #(.GAP_BITS(GAP), .CRC_SEED(7'h00)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .cmd     (bus),
    .cmd_out (cmd_out),
    .cmd_oe  (cmd_oe),
    .busy    (busy),
    .done    (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [47:0] frame;
    int          nbits;
    int          acc_cyc;
    int          delta;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   frames_seen = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference CRC: remainder of header*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_ref(input logic [39:0] hdr);
    logic [46:0] r;
    r = {hdr, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] mkframe(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    hdr = {2'b01, idx, arg};
    return {hdr, crc7_ref(hdr), 1'b1};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        in_frame = 1'b0;
  logic [47:0] bits;
  int          nb, done_at, start_cyc;
  int          last_start = -1000;

  always @(negedge CLK) begin
    exp_t e;
    if (!RSTn) begin
      in_frame = 1'b0;
    end else begin
      chk("busy_vs_ready", 64'(busy), 64'(!bus.cmd_ready));
      if (cmd_oe) begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          nb        = 0;
          bits      = '0;
          done_at   = 0;
          start_cyc = cyc;
        end
        bits = {bits[46:0], cmd_out};
        nb++;
        if (done) done_at = nb;
        chk("ready_low_in_frame", 64'(bus.cmd_ready), 64'(0));
      end else begin
        chk("idle_line_high", 64'(cmd_out), 64'(1));
        chk("no_done_when_idle", 64'(done), 64'(0));
        if (in_frame) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame actual=%0d_bits required=none", nb);
          end else begin
            e = exp_q.pop_front();
            frames_seen++;
            chk("frame_len", 64'(nb), 64'(e.nbits));
            chk("frame_bits", 64'(bits), 64'(e.frame >> (48 - e.nbits)));
            chk("done_pos", 64'(done_at), 64'((e.nbits == 48) ? 48 : 0));
            chk("start_latency", 64'(start_cyc - e.acc_cyc), 64'(2));
            if (e.delta > 0)
              chk("b2b_spacing", 64'(start_cyc - last_start), 64'(e.delta));
          end
          last_start = start_cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // abort_at < 0: full frame; otherwise abort is held during post-accept cycle abort_at.
  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] frame,
                      input int abort_at, input int delta, input bit hold);
    exp_t e;
    int   t = 0;
    @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    while (!bus.cmd_ready && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
      bus.cmd_valid = 1'b0;
      return;
    end
    e.frame   = frame;
    e.nbits   = (abort_at >= 0) ? abort_at : 48;
    e.acc_cyc = cyc;
    e.delta   = delta;
    exp_q.push_back(e);
    pushed++;
    @(posedge CLK);
    @(negedge CLK);
    if (!hold) begin
      bus.cmd_valid = 1'b0;
      bus.cmd_index = 6'($urandom);
      bus.cmd_arg   = $urandom;
    end
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge CLK);
      bus.abort = 1'b1;
      @(negedge CLK);
      bus.abort = 1'b0;
    end
  endtask

  initial begin
    logic [5:0]  ri;
    logic [31:0] ra;
    int          t;
    bus.cmd_valid = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.abort     = 1'b0;

    repeat (3) @(negedge CLK);
    chk("rst_cmd_out", 64'(cmd_out), 64'(1));
    chk("rst_cmd_oe", 64'(cmd_oe), 64'(0));
    chk("rst_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    #2 RSTn = 1'b1;

    send(6'd0,  32'h0,        48'h40_0000_0000_95, -1, -1, 1'b0);
    send(6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, -1, -1, 1'b0);
    send(6'd17, 32'h0,        48'h51_0000_0000_55, -1, -1, 1'b0);

    // back-to-back with valid held high throughout
    send(6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, -1, -1, 1'b1);
    send(6'd0,  32'h0,        48'h40_0000_0000_95, -1, 48 + GAP + 1, 1'b0);

    // abort in header bit 20, then a clean CMD0
    ri = 6'($urandom); ra = $urandom;
    send(ri, ra, mkframe(ri, ra), 20, -1, 1'b0);
    send(6'd0, 32'h0, 48'h40_0000_0000_95, -1, -1, 1'b0);
    // abort on the first CRC bit and on the end bit
    send(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, 40, -1, 1'b0);
    send(6'd17, 32'h0, 48'h51_0000_0000_55, 47, -1, 1'b0);
    send(6'd0, 32'h0, 48'h40_0000_0000_95, -1, -1, 1'b0);

    // reset in the middle of the CRC phase
    send(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, -1, -1, 1'b0);
    repeat (43) @(negedge CLK);
    #2 RSTn = 1'b0;
    exp_q.delete();
    pushed--;
    #1;
    chk("async_rst_cmd_out", 64'(cmd_out), 64'(1));
    chk("async_rst_cmd_oe", 64'(cmd_oe), 64'(0));
    chk("async_rst_ready", 64'(bus.cmd_ready), 64'(1));
    @(negedge CLK);
    #2 RSTn = 1'b1;
    send(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, -1, -1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 14; n++) begin
      int ab;
      ri = 6'($urandom);
      ra = $urandom;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 47)) : -1;
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      send(ri, ra, mkframe(ri, ra), ab, -1, 1'b0);
    end

    t = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("frames_seen", 64'(frames_seen), 64'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
